// File: rtl/tb_hook_pkg.sv
// tb_hook_pkg: command/state encodings and index-width helper shared by the hook scheduler files
package tb_hook_pkg;
  typedef enum logic [1:0] {CMD_PUTC, CMD_QUERY, CMD_PASS, CMD_FAIL} cmd_e;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RESP} state_e;
  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tb_hook_rr_arbiter.sv
// tb_hook_rr_arbiter: picks the first asserted request at or after the pointer, wrapping
module tb_hook_rr_arbiter
  import tb_hook_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int SRC_W = src_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [SRC_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt_oh,
  output logic [SRC_W-1:0]   o_gnt_idx,
  output logic               o_gnt_any
);
  always_comb begin
    o_gnt_oh = '0;
    o_gnt_idx = '0;
    o_gnt_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!o_gnt_any && i_req[(int'(i_ptr) + k) % NUM_REQ]) begin
        o_gnt_any = 1'b1;
        o_gnt_idx = SRC_W'((int'(i_ptr) + k) % NUM_REQ);
        o_gnt_oh[(int'(i_ptr) + k) % NUM_REQ] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/tb_hook_scheduler.sv
// tb_hook_scheduler: round-robin sharing of the testbench hook channel with sticky end-of-test status.
// Define TB_HOOK_TIMEOUT_EN to add the response watchdog (TIMEOUT_CYCLES).
module tb_hook_scheduler
  import tb_hook_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int SRC_W = src_w(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [2*NUM_REQ-1:0]      req_cmd,
  input  logic [DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      hook_valid,
  input  logic                      hook_ready,
  output logic [1:0]                hook_cmd,
  output logic [SRC_W-1:0]          hook_src,
  output logic [DATA_W-1:0]         hook_data,
  input  logic                      hook_rsp_valid,
  input  logic [DATA_W-1:0]         hook_rsp_data,
  output logic                      test_done,
  output logic                      test_pass,
  output logic                      timeout_err
);
  state_e r_state, w_next;
  cmd_e r_cmd;
  logic [SRC_W-1:0] r_ptr, r_src, w_gnt_idx;
  logic [DATA_W-1:0] r_data, r_rsp_data;
  logic [NUM_REQ-1:0] w_gnt_oh;
  logic r_done, r_pass, w_gnt_any, w_accept, w_hook_hs, w_tmo;

  tb_hook_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req(req_valid),
    .i_ptr(r_ptr),
    .o_gnt_oh(w_gnt_oh),
    .o_gnt_idx(w_gnt_idx),
    .o_gnt_any(w_gnt_any)
  );

  assign w_accept = r_state == IDLE && !r_done && w_gnt_any;
  assign w_hook_hs = r_state == ISSUE && hook_ready;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     w_next = w_accept ? ISSUE : IDLE;
      ISSUE:    w_next = w_tmo ? RESP : hook_ready ? (r_cmd == CMD_QUERY ? WAIT_RSP : RESP) : ISSUE;
      WAIT_RSP: w_next = (hook_rsp_valid || w_tmo) ? RESP : WAIT_RSP;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_src <= '0;
      r_cmd <= CMD_PUTC;
      r_data <= '0;
      r_rsp_data <= '0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_src <= w_gnt_idx;
        r_cmd <= cmd_e'(req_cmd[w_gnt_idx*2 +: 2]);
        r_data <= req_data[w_gnt_idx*DATA_W +: DATA_W];
        r_ptr <= (int'(w_gnt_idx) == NUM_REQ - 1) ? '0 : w_gnt_idx + 1'b1;
      end
      if (w_tmo || (w_hook_hs && r_cmd != CMD_QUERY))
        r_rsp_data <= '0;
      else if (r_state == WAIT_RSP && hook_rsp_valid)
        r_rsp_data <= hook_rsp_data;
      if (w_hook_hs && (r_cmd == CMD_PASS || r_cmd == CMD_FAIL)) begin
        r_done <= 1'b1;
        r_pass <= r_cmd == CMD_PASS;
      end
    end
  end

`ifdef TB_HOOK_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
  logic r_rsp_err, r_tmo_err;
  // Watchdog fires only in a cycle with no forward progress
  assign w_tmo = ((r_state == ISSUE && !hook_ready) || (r_state == WAIT_RSP && !hook_rsp_valid))
                 && r_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
      r_rsp_err <= 1'b0;
      r_tmo_err <= 1'b0;
    end else begin
      r_cnt <= w_accept ? '0 : (r_state == ISSUE || r_state == WAIT_RSP) ? r_cnt + 1'b1 : r_cnt;
      if (r_state != RESP && w_next == RESP) r_rsp_err <= w_tmo;
      if (w_tmo) r_tmo_err <= 1'b1;
    end
  end
  assign rsp_err = r_rsp_err;
  assign timeout_err = r_tmo_err;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
  assign w_tmo = 1'b0;
  assign rsp_err = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign req_ready = (r_state == IDLE && !r_done) ? w_gnt_oh : '0;
  assign hook_valid = r_state == ISSUE;
  assign hook_cmd = r_cmd;
  assign hook_src = r_src;
  assign hook_data = r_data;
  assign rsp_valid = (r_state == RESP) ? NUM_REQ'(1) << r_src : '0;
  assign rsp_data = r_rsp_data;
  assign test_done = r_done;
  assign test_pass = r_pass;
endmodule

// File: tb/tb_tb_hook_scheduler.sv
// tb_tb_hook_scheduler: randomized transactions against a round-robin transaction model of the hook scheduler
module tb_tb_hook_scheduler;
  localparam int N = 4, DW = 32, TO = 16;
  localparam logic [1:0] PUTC = 2'd0, QUERY = 2'd1, PASS = 2'd2, FAIL = 2'd3;
  logic clock = 1'b0, reset = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready, rsp_valid;
  logic [2*N-1:0] req_cmd = '0;
  logic [DW*N-1:0] req_data = '0;
  logic [DW-1:0] rsp_data, hook_data, hook_rsp_data = '0;
  logic rsp_err, hook_valid, hook_ready = 1'b0, hook_rsp_valid = 1'b0;
  logic test_done, test_pass, timeout_err;
  logic [1:0] hook_cmd, hook_src;
  int errors = 0, checks = 0, ptr = 0;
  logic [N-1:0] m, acc;
  logic [2*N-1:0] cm;
  logic [DW*N-1:0] dm;

  always #5 clock = ~clock;

  tb_hook_scheduler #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .hook_valid(hook_valid), .hook_ready(hook_ready), .hook_cmd(hook_cmd),
    .hook_src(hook_src), .hook_data(hook_data),
    .hook_rsp_valid(hook_rsp_valid), .hook_rsp_data(hook_rsp_data),
    .test_done(test_done), .test_pass(test_pass), .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++)
      if (mask[(ptr + i) % N]) return (ptr + i) % N;
    return 0;
  endfunction

  task automatic do_reset();
    req_valid = '0;
    hook_ready = 1'b0;
    hook_rsp_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    ptr = 0;
    check("rst_ctl", {req_ready, rsp_valid, rsp_err, hook_valid, hook_cmd, hook_src,
                      test_done, test_pass, timeout_err}, '0);
    check("rst_data", {rsp_data, hook_data}, '0);
  endtask

  // One full transaction; mask must be nonzero and the scheduler idle
  task automatic txn(input logic [N-1:0] mask, input logic [2*N-1:0] cmds, input logic [DW*N-1:0] datas,
                     input int rdy_dly, input int rsp_dly, input logic [DW-1:0] rdat);
    int g;
    logic [1:0] c;
    g = pick(mask);
    c = cmds[2*g +: 2];
    req_valid = mask;
    req_cmd = cmds;
    req_data = datas;
    #1;
    check("grant", req_ready, 64'(1) << g);
    @(negedge clock);
    ptr = (g + 1) % N;
    repeat (rdy_dly) @(negedge clock);
    check("hook_valid", hook_valid, 1);
    check("hook_src", hook_src, g);
    check("hook_cmd", hook_cmd, c);
    check("hook_data", hook_data, datas[g*DW +: DW]);
    hook_ready = 1'b1;
    @(negedge clock);
    hook_ready = 1'b0;
    if (c == QUERY) begin
      acc = '0;
      repeat (rsp_dly) begin
        acc |= rsp_valid;
        @(negedge clock);
      end
      check("query_early", acc, 0);
      hook_rsp_valid = 1'b1;
      hook_rsp_data = rdat;
      @(negedge clock);
      hook_rsp_valid = 1'b0;
      check("rsp_valid", rsp_valid, 64'(1) << g);
      check("rsp_data", rsp_data, rdat);
    end else begin
      check("rsp_valid", rsp_valid, 64'(1) << g);
      check("rsp_data", rsp_data, 0);
    end
    check("rsp_err", rsp_err, 0);
    @(negedge clock);
    check("rsp_pulse", rsp_valid, 0);
    req_valid = '0;
  endtask

  initial begin
    @(negedge clock);
    do_reset();
    txn(4'b0100, {PUTC, PUTC, PUTC, PUTC}, {32'h0, 32'h41, 32'h0, 32'h0}, 0, 0, 0);
    txn(4'b0001, {PUTC, PUTC, PUTC, QUERY}, {32'h0, 32'h0, 32'h0, 32'h1234}, 0, 5, 32'hDEADBEEF);
    do_reset();
    for (int i = 0; i < 5; i++)
      txn(4'b1111, '0, {32'h33 + i, 32'h22 + i, 32'h11 + i, 32'h00 + i}, 0, 0, 0);
    for (int t = 0; t < 40; t++) begin
      m = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) cm[2*i +: 2] = 2'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) dm[i*DW +: DW] = $urandom;
      txn(m, cm, dm, $urandom_range(0, 3), $urandom_range(0, 4), $urandom);
    end
    // Reset while waiting for a QUERY result
    req_valid = 4'b0100;
    req_cmd = {PUTC, QUERY, PUTC, PUTC};
    #1;
    check("midop_grant", req_ready, 4'b0100);
    @(negedge clock);
    req_valid = '0;
    hook_ready = 1'b1;
    @(negedge clock);
    hook_ready = 1'b0;
    check("midop_wait", hook_valid, 0);
    @(negedge clock);
    do_reset();
    hook_rsp_valid = 1'b1;
    hook_rsp_data = 32'hCAFE;
    @(negedge clock);
    hook_rsp_valid = 1'b0;
    acc = rsp_valid;
    repeat (3) begin
      @(negedge clock);
      acc |= rsp_valid;
    end
    check("midop_no_rsp", acc, 0);
`ifdef TB_HOOK_TIMEOUT_EN
    req_valid = 4'b0001;
    req_cmd = {PUTC, PUTC, PUTC, QUERY};
    @(negedge clock);
    req_valid = '0;
    hook_ready = 1'b1;
    @(negedge clock);
    hook_ready = 1'b0;
    acc = '0;
    for (int i = 0; i < 15; i++) begin
      acc |= rsp_valid;
      @(negedge clock);
    end
    check("tmo_early", acc, 0);
    check("tmo_rsp", rsp_valid, 4'b0001);
    check("tmo_err", rsp_err, 1);
    check("tmo_data", rsp_data, 0);
    check("tmo_flag", timeout_err, 1);
    @(negedge clock);
    hook_rsp_valid = 1'b1;
    @(negedge clock);
    hook_rsp_valid = 1'b0;
    check("tmo_late", rsp_valid, 0);
    check("tmo_sticky", timeout_err, 1);
    ptr = 1;
`endif
    txn(4'b0001, {PUTC, PUTC, PUTC, FAIL}, {32'h0, 32'h0, 32'h0, 32'h5}, 1, 0, 0);
    check("fail_done", test_done, 1);
    check("fail_pass", test_pass, 0);
    req_valid = 4'b0001;
    #1;
    check("fail_block", req_ready, 0);
    do_reset();
    txn(4'b0010, {PUTC, PUTC, PASS, PUTC}, {32'h0, 32'h0, 32'h1, 32'h0}, 2, 0, 0);
    check("pass_done", test_done, 1);
    check("pass_pass", test_pass, 1);
    req_valid = 4'b1000;
    req_cmd = {PUTC, PUTC, PUTC, PUTC};
    acc = '0;
    repeat (100) begin
      @(negedge clock);
      acc |= req_ready | {3'b0, hook_valid};
    end
    check("post_done_block", acc, 0);
    check("post_done_sticky", {test_done, test_pass}, 2'b11);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
